// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DataWidth = 32;
  // LO value that a divide by zero returns.
  localparam logic [DataWidth-1:0] DivZeroLo = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: a shift-add multiply step or a restoring divide step.
// Multiply: acc = {partial product, multiplier}. Divide: acc = {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic                   isDiv,
  input  logic [2*DataWidth-1:0] accIn,
  input  logic [DataWidth-1:0]   operand,
  output logic [2*DataWidth-1:0] accOut
);

  localparam int unsigned W = DataWidth;

  logic [W:0]   sum;
  logic [W:0]   remShift;
  logic [W-1:0] diffLo;
  logic         canSub;

  always_comb begin
    sum      = {1'b0, accIn[2*W-1:W]} + (accIn[0] ? {1'b0, operand} : {(W + 1){1'b0}});
    remShift = {accIn[2*W-1:W], accIn[W-1]};
    canSub   = remShift >= {1'b0, operand};
    // Remainder after a successful subtract is below the divisor, so W bits suffice.
    diffLo   = remShift[W-1:0] - operand;
    if (!isDiv) begin
      accOut = {sum, accIn[W-1:1]};
    end else if (canSub) begin
      accOut = {diffLo, accIn[W-2:0], 1'b1};
    end else begin
      accOut = {remShift[W-1:0], accIn[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Sequenced multiply/divide unit writing architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        muldivE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        mfloM,
  input  logic        mfhiM,
  output logic        busy,
  output logic        done,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W = DataWidth;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  muldiv_state_e  stateQ, stateD;
  muldiv_op_e     opQ;
  logic [4:0]     cntQ;
  logic [2*W-1:0] accQ, accStep, accInit;
  logic [W-1:0]   operandQ;
  logic           negQ, remNegQ, divZeroQ;
  logic [W-1:0]   hiQ, loQ;

  logic           startIsDiv, signedOp, aNeg, bNeg, isDivQ;
  logic [W-1:0]   magA, magB;
  logic [2*W-1:0] prodFix;
  logic [W-1:0]   quoFix, remFix;

  // Operand magnitudes and signs for the request presented this cycle.
  always_comb begin
    startIsDiv = opE[1];
    signedOp   = !opE[0];
    aNeg       = signedOp & srcaE[W-1];
    bNeg       = signedOp & srcbE[W-1];
    magA       = aNeg ? -srcaE : srcaE;
    magB       = bNeg ? -srcbE : srcbE;
    accInit    = startIsDiv ? {{W{1'b0}}, magA} : {{W{1'b0}}, magB};
`ifdef MULDIV_FAST_MUL_EN
    if (!startIsDiv) begin
      accInit = {{W{1'b0}}, magA} * {{W{1'b0}}, magB};
    end
`endif
  end

  assign isDivQ = (opQ == OpDiv) || (opQ == OpDivu);

  muldiv_step stepUnit (
    .isDiv  (isDivQ),
    .accIn  (accQ),
    .operand(operandQ),
    .accOut (accStep)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (muldivE) begin
          stateD = (FastMul && !startIsDiv) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (cntQ == 5'(W - 1)) begin
          stateD = StFix;
        end
      end
      StFix:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Sign correction; a zero divisor overrides the quotient, the remainder already equals srcaE.
  always_comb begin
    prodFix = negQ ? -accQ : accQ;
    quoFix  = divZeroQ ? DivZeroLo : (negQ ? -accQ[W-1:0] : accQ[W-1:0]);
    remFix  = remNegQ ? -accQ[2*W-1:W] : accQ[2*W-1:W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= StIdle;
      opQ      <= OpMult;
      cntQ     <= '0;
      accQ     <= '0;
      operandQ <= '0;
      negQ     <= 1'b0;
      remNegQ  <= 1'b0;
      divZeroQ <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
    end else begin
      stateQ <= stateD;
      unique case (stateQ)
        StIdle: begin
          if (muldivE) begin
            accQ     <= accInit;
            operandQ <= startIsDiv ? magB : magA;
            opQ      <= muldiv_op_e'(opE);
            negQ     <= aNeg ^ bNeg;
            remNegQ  <= aNeg;
            divZeroQ <= (srcbE == '0);
            cntQ     <= '0;
          end
        end
        StCalc: begin
          accQ <= accStep;
          cntQ <= cntQ + 5'd1;
        end
        StFix: begin
          if (isDivQ) begin
            hiQ <= remFix;
            loQ <= quoFix;
          end else begin
            hiQ <= prodFix[2*W-1:W];
            loQ <= prodFix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (stateQ == StCalc) || (stateQ == StFix);
  assign done = (stateQ == StFix);
  assign hi   = hiQ;
  assign lo   = loQ;

  always_comb begin
    if (mfloM) begin
      hilo_rdata = loQ;
    end else if (mfhiM) begin
      hilo_rdata = hiQ;
    end else begin
      hilo_rdata = '0;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {HI,LO}, a monitor checks on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        muldivE = 1'b0;
  logic [1:0]  opE = 2'b00;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        mfloM = 1'b1;
  logic        mfhiM = 1'b0;
  logic        busy, done;
  logic [31:0] hilo_rdata, hi, lo;

  int passCnt = 0;
  int totalCnt = 0;
  logic [63:0] expQ[$];
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulBusy = 1;
`else
  localparam int MulBusy = 33;
`endif
  localparam int DivBusy = 33;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .muldivE   (muldivE),
    .opE       (opE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .mfloM     (mfloM),
    .mfhiM     (mfhiM),
    .busy      (busy),
    .done      (done),
    .hilo_rdata(hilo_rdata),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue one operation at a negedge and count busy cycles; optionally re-assert mid-flight.
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int expBusy,
                       input bit inject);
    int cycles = 0;
    opE = op;
    srcaE = a;
    srcbE = b;
    muldivE = 1'b1;
    expQ.push_back(exp);
    @(negedge clk);
    muldivE = 1'b0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (inject && cycles == 10) begin
        muldivE = 1'b1;
        opE = 2'b00;
        srcaE = 32'd5;
        srcbE = 32'd6;
      end else begin
        muldivE = 1'b0;
      end
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(cycles), 64'(expBusy));
  endtask

  initial begin : monitor
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("read_during_done", hilo_rdata, lastLo);
        @(negedge clk);
        check("done_pulse", done, 64'd0);
        if (expQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, required no result", hi, lo);
        end else begin
          exp = expQ.pop_front();
          check("hi", hi, exp[63:32]);
          check("lo", lo, exp[31:0]);
          lastHi = exp[63:32];
          lastLo = exp[31:0];
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_hi", hi, 64'd0);
    check("rst_lo", lo, 64'd0);
    check("rst_rdata", hilo_rdata, 64'd0);

    reset = 1'b1;
    runOp("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, MulBusy, 0);
    runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MulBusy, 0);
    runOp("mult_pos", 2'b00, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, MulBusy, 0);
    runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, DivBusy, 0);
    runOp("div_negb", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DivBusy, 0);
    runOp("divu", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DivBusy, 0);
    runOp("divu_zero", 2'b11, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, DivBusy, 0);
    runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DivBusy, 0);
    runOp("mult_reassert", 2'b00, 32'd3, 32'd4, 64'h0000_0000_0000_000C, MulBusy, 1);
    runOp("div_zero_neg", 2'b10, 32'hFFFF_FFF8, 32'd0, 64'hFFFF_FFF8_FFFF_FFFF, DivBusy, 0);

    // Abort an in-flight divide with reset at busy cycle 15; no result is expected.
    opE = 2'b11;
    srcaE = 32'd100;
    srcbE = 32'd7;
    muldivE = 1'b1;
    @(negedge clk);
    muldivE = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_mid", busy, 64'd1);
    mfloM = 1'b1;
    mfhiM = 1'b1;
    #1 check("rd_lo_priority", hilo_rdata, lastLo);
    mfloM = 1'b0;
    #1 check("rd_hi", hilo_rdata, lastHi);
    mfhiM = 1'b0;
    #1 check("rd_none", hilo_rdata, 64'd0);
    mfloM = 1'b1;
    mfhiM = 1'b1;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 64'd0);
    check("abort_done", done, 64'd0);
    check("abort_hi", hi, 64'd0);
    check("abort_lo", lo, 64'd0);
    check("abort_rdata", hilo_rdata, 64'd0);
    lastHi = '0;
    lastLo = '0;
    @(negedge clk);
    @(negedge clk);
    check("held_busy", busy, 64'd0);
    mfhiM = 1'b0;
    reset = 1'b1;
    runOp("after_reset", 2'b01, 32'd2, 32'd3, 64'h0000_0000_0000_0006, MulBusy, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
